// File: rtl/ad9122_spi_pkg.sv
// ad9122_spi_pkg: frame layout, register addresses and FSM encodings for the AD9122 SPI target model
package ad9122_spi_pkg;
    localparam int INFO_W = 8;
    localparam int DATA_W = 8;
    localparam int FRAME_W = INFO_W + DATA_W;
    localparam int RW_BIT = FRAME_W - 1;
    localparam logic [6:0] ADDR_SPI_CTL = 7'h00;
    localparam logic [6:0] ADDR_FIFO_CTL = 7'h18;
    localparam logic [6:0] ADDR_FIFO_STAT = 7'h19;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_INSTR = 3'd1;
    localparam logic [2:0] S_WR_DATA = 3'd2;
    localparam logic [2:0] S_RD_DATA = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: 2-flop synchronizer with rise/fall detection on the synchronized level
module spi_edge_sync (
    input  logic clk,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic [2:0] s;
    always_ff @(posedge clk) s <= {s[1:0], din};
    assign rise = s[1] & ~s[2];
    assign fall = ~s[1] & s[2];
endmodule

// File: rtl/ad9122_spi_target_model.sv
// ad9122_spi_target_model: SPI register-file target modelling the AD9122 control port
module ad9122_spi_target_model
    import ad9122_spi_pkg::*;
#(
    parameter int ALIGN_LATENCY = 16,
    parameter int RD_TURNAROUND = 0
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       i_sclk,
    input  logic       i_sen_n,
    input  logic       i_sda,
    input  logic       i_dac_reset,
    input  logic [7:0] i_fifo_level,
    output logic       o_sda,
    output logic       o_sda_dir,
    output logic       o_wr_strobe,
    output logic [6:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    output logic       o_frame_err
);
    logic rst_all, sclk_rise, sclk_fall, sen_rise, sen_fall, sda_s;
    logic [1:0] sda_q;
    logic [2:0] state;
    logic [7:0] cnt, skip, rd_sh;
    logic [INFO_W-1:0] sh, sh_nxt;
    logic [6:0] addr;
    logic [7:0] regs [128];
    logic [15:0] align_cnt;
    assign rst_all = rst | i_dac_reset;
    assign sda_s = sda_q[1];
    assign sh_nxt = {sh[INFO_W-2:0], sda_s};
    spi_edge_sync u_sclk (.clk(clk_in), .din(i_sclk), .rise(sclk_rise), .fall(sclk_fall));
    spi_edge_sync u_sen (.clk(clk_in), .din(i_sen_n), .rise(sen_rise), .fall(sen_fall));
    always_ff @(posedge clk_in) sda_q <= {sda_q[0], i_sda};
    // frame FSM; sen_n rise in any active state aborts, in DONE it closes normally
    always_ff @(posedge clk_in) begin
        if (rst_all) begin
            state <= S_IDLE;
            cnt <= '0;
            skip <= '0;
            sh <= '0;
            addr <= '0;
            rd_sh <= '0;
            o_sda <= 1'b0;
            o_sda_dir <= 1'b0;
            o_wr_strobe <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
            o_frame_err <= 1'b0;
        end else begin
            o_wr_strobe <= 1'b0;
            o_frame_err <= 1'b0;
            if (sen_rise) begin
                o_frame_err <= state != S_IDLE && state != S_DONE;
                state <= S_IDLE;
                cnt <= '0;
                o_sda <= 1'b0;
                o_sda_dir <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (sen_fall) begin
                        state <= S_INSTR;
                        cnt <= '0;
                    end
                    S_INSTR: if (sclk_rise) begin
                        sh <= sh_nxt;
                        cnt <= cnt + 8'd1;
                        if (cnt == 8'(INFO_W - 1)) begin
                            cnt <= '0;
                            addr <= sh_nxt[6:0];
                            state <= sh_nxt[RW_BIT-DATA_W] ? S_RD_DATA : S_WR_DATA;
                            rd_sh <= sh_nxt[6:0] == ADDR_FIFO_STAT ? i_fifo_level : regs[sh_nxt[6:0]];
                            skip <= 8'(RD_TURNAROUND);
                        end
                    end
                    S_WR_DATA: if (sclk_rise) begin
                        sh <= sh_nxt;
                        cnt <= cnt + 8'd1;
                        if (cnt == 8'(DATA_W - 1)) begin
                            state <= S_DONE;
                            o_wr_strobe <= 1'b1;
                            o_wr_addr <= addr;
                            o_wr_data <= sh_nxt;
                        end
                    end
                    S_RD_DATA: begin
                        if (sclk_rise) begin
                            cnt <= cnt + 8'd1;
                            if (cnt == 8'(DATA_W + RD_TURNAROUND - 1)) begin
                                state <= S_DONE;
                                o_sda <= 1'b0;
                                o_sda_dir <= 1'b0;
                            end
                        end else if (sclk_fall) begin
                            if (skip != 8'd0) skip <= skip - 8'd1;
                            else begin
                                o_sda_dir <= 1'b1;
                                o_sda <= rd_sh[7];
                                rd_sh <= {rd_sh[6:0], 1'b0};
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
    // register file: soft reset takes effect the cycle after 0x00 bit7 lands
    always_ff @(posedge clk_in) begin
        if (rst_all) begin
            for (int i = 0; i < 128; i++) regs[i] <= 8'h00;
            align_cnt <= '0;
        end else if (regs[ADDR_SPI_CTL][7]) begin
            for (int i = 0; i < 128; i++) regs[i] <= 8'h00;
            regs[ADDR_SPI_CTL] <= {1'b0, regs[ADDR_SPI_CTL][6:0]};
            align_cnt <= '0;
        end else begin
            if (align_cnt != 16'd0) align_cnt <= align_cnt - 16'd1;
            if (align_cnt == 16'd1) regs[ADDR_FIFO_CTL] <= regs[ADDR_FIFO_CTL] | 8'h05;
            if (o_wr_strobe && o_wr_addr != ADDR_FIFO_STAT) regs[o_wr_addr] <= o_wr_data;
            if (o_wr_strobe && o_wr_addr == ADDR_FIFO_CTL)
                align_cnt <= o_wr_data[1] ? 16'(ALIGN_LATENCY) : 16'd0;
        end
    end
endmodule

// File: doc/ad9122_spi_target_model.md
AD9122_SPI_TARGET_MODEL -- requirements
Module: ad9122_spi_target_model

Interface
REQ-001 SHALL have parameter ALIGN_LATENCY, default 16, meaning clk_in cycles from FIFO align request to acknowledge.
REQ-002 SHALL have parameter RD_TURNAROUND, default 0, meaning extra SCLK falling edges before read data is driven (0 = first data bit after the 8th rising edge).
REQ-003 clk_in  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 i_sclk  input  1  SPI clock from the master, asynchronous to clk_in.
REQ-006 i_sen_n  input  1  active-low chip select.
REQ-007 i_sda  input  1  SDIO value driven by the master.
REQ-008 i_dac_reset  input  1  DAC hardware RESET pin, active-high.
REQ-009 i_fifo_level  input  8  FIFO status value returned at address 0x19.
REQ-010 o_sda  output  1  SDIO value driven by the target.
REQ-011 o_sda_dir  output  1  1 = target drives SDIO.
REQ-012 o_wr_strobe  output  1  one-cycle pulse per committed write.
REQ-013 o_wr_addr / o_wr_data  output  7 / 8  address and data of the committed write.
REQ-014 o_frame_err  output  1  one-cycle pulse when a frame is aborted.

Function
REQ-015 SHALL pass i_sclk, i_sen_n and i_sda through 2-flop synchronizers, then detect SCLK rise and fall edges; the clk_in frequency is at least 8x the SCLK frequency.
REQ-016 SHALL use the frame format: 16 bits, MSB first, sampled on SCLK rise; bit15 is R/W (1 = read), bits14:8 are the address, bits7:0 are the data.
REQ-017 SHALL use states IDLE, INSTR, WR_DATA, RD_DATA, DONE. The transitions are:
- IDLE -> INSTR on sen_n fall.
- INSTR -> WR_DATA or RD_DATA after 8 rises.
- WR_DATA -> DONE after 8 further rises.
- RD_DATA -> DONE after 8 shifted bits.
- DONE -> IDLE on sen_n rise.
REQ-018 Write commit: on the 16th rise, regfile[addr] SHALL be updated and o_wr_strobe/o_wr_addr/o_wr_data asserted, both within 1 clk_in cycle.
REQ-019 Read: at the 8th rise, SHALL latch the read value; o_sda_dir SHALL go 1 and o_sda SHALL present bit7 after the next SCLK fall, then shift one bit per fall; o_sda_dir SHALL return to 0 in DONE or on sen_n rise.
REQ-020 sen_n rise before 16 bits SHALL abort the frame with no register change, pulse o_frame_err, return to IDLE, and clear the bit counter.
REQ-021 SCLK edges while sen_n is high SHALL be ignored.
REQ-022 Register file SHALL be 128 x 8, reset value 0x00.
REQ-023 Address 0x19 SHALL be read-only: reads return i_fifo_level sampled at the 8th rise, and writes are ignored (strobe still pulses).
REQ-024 Address 0x00 bit7 (soft reset) write SHALL clear all registers to 0x00 on the following cycle; bit7 self-clears, and the other written bits of 0x00 are retained.
REQ-025 Address 0x18 behaviour:
- Writing bit1 = 1 starts a counter.
- After ALIGN_LATENCY cycles, bits2 and 0 are set (reads 0x07).
- Writing 0x00 clears the register and the counter.
- A new request while counting restarts the count.
REQ-026 Frames back-to-back (sen_n held low beyond 16 bits) SHALL NOT auto-increment; extra bits are ignored until sen_n rises.

Reset
REQ-027 rst or i_dac_reset SHALL force: state IDLE, regfile all 0x00, 0x18 counter cleared, o_sda=0, o_sda_dir=0, o_wr_strobe=0, o_wr_addr=0, o_wr_data=0, o_frame_err=0.
REQ-028 Reset asserted mid-frame SHALL discard the frame without an o_frame_err pulse; the next frame SHALL be accepted only after a fresh sen_n fall.

Structure
REQ-029 Shared package ad9122_spi_pkg SHALL hold the frame widths (INFO 8, DATA 8), the R/W bit position, and address constants 0x00, 0x18, 0x19.
REQ-030 SHALL instantiate one sub-module, spi_edge_sync (synchronizer plus rise/fall detect), used for SCLK and reused for sen_n.

Verification
REQ-031 Write 0x1B=0xA4, then read 0x1B -> o_wr_strobe with addr 0x1B, data 0xA4; the read shifts out 0xA4 with o_sda_dir high for exactly 8 bits.
REQ-032 Write 0x18=0x02, read immediately, wait ALIGN_LATENCY+4 cycles, read again -> first read 0x02, second read 0x07; write 0x18=0x00 -> read 0x00.
REQ-033 i_fifo_level=0x0F, read 0x19; then write 0x19=0x55 and read -> both reads return 0x0F.
REQ-034 Write 0x1E=0x01, then write 0x00=0x80, then read 0x1E and 0x00 -> both 0x00.
REQ-035 Raise sen_n after 11 bits of a write to 0x30 -> o_frame_err pulse, no o_wr_strobe, 0x30 unchanged; the next full write succeeds.
REQ-036 Pulse i_dac_reset for 10 cycles after writing 0x36=0x01 -> 0x36 reads 0x00; o_sda_dir=0 throughout reset.
